// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator feeding the TMDS stage, one-cycle output pipeline.
// Define VTG_PATTERN_EN to replace PixelIn with an 8-bar colour test pattern.
module video_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        PixelClk,
  input  logic        RstB,
  input  logic        Enable,
  input  logic [23:0] PixelIn,
  output logic        PixelReq,
  output logic [23:0] VideoDout,
  output logic        VideoDE,
  output logic        VideoHSync,
  output logic        VideoVSync,
  output logic [11:0] HCount,
  output logic [11:0] VCount,
  output logic        FrameStart,
  output logic        Busy
);

  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]  state;
  logic [11:0] hcnt;
  logic [11:0] vcnt;
  logic        isRun;
  logic        lineEnd;
  logic        frameEnd;
  logic        hsActive;
  logic        vsActive;
  logic [23:0] pixelNext;

  assign isRun    = (state == RUN);
  assign lineEnd  = (hcnt == H_LAST);
  assign frameEnd = lineEnd && (vcnt == V_LAST);
  assign Busy     = isRun;
  assign PixelReq = isRun && (hcnt < H_ACT) && (vcnt < V_ACT);
  assign hsActive = isRun && (hcnt >= HS_START) && (hcnt < HS_END);
  assign vsActive = isRun && (vcnt >= VS_START) && (vcnt < VS_END);

  // Counters only leave (0,0) while running, and RUN is only exited at the frame wrap.
  always_ff @(posedge PixelClk or negedge RstB) begin
    if (!RstB) begin
      state <= IDLE;
      hcnt  <= '0;
      vcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Enable) state <= RUN;
        end
        RUN: begin
          if (lineEnd) begin
            hcnt <= '0;
            if (frameEnd) begin
              vcnt <= '0;
              if (!Enable) state <= IDLE;
            end else begin
              vcnt <= vcnt + 12'd1;
            end
          end else begin
            hcnt <= hcnt + 12'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VTG_PATTERN_EN
  localparam logic [11:0] BAR_W = 12'(H_ACTIVE / 8);
  logic [2:0] barIdx;
  assign barIdx = 3'(hcnt / BAR_W);

  always_comb begin
    pixelNext = 24'h000000;
    case (barIdx)
      3'd0: pixelNext = 24'hFFFFFF;
      3'd1: pixelNext = 24'hFFFF00;
      3'd2: pixelNext = 24'h00FFFF;
      3'd3: pixelNext = 24'h00FF00;
      3'd4: pixelNext = 24'hFF00FF;
      3'd5: pixelNext = 24'hFF0000;
      3'd6: pixelNext = 24'h0000FF;
      default: pixelNext = 24'h000000;
    endcase
  end
`else
  assign pixelNext = PixelIn;
`endif

  always_ff @(posedge PixelClk or negedge RstB) begin
    if (!RstB) begin
      VideoDout  <= '0;
      VideoDE    <= 1'b0;
      VideoHSync <= ~HS_POL;
      VideoVSync <= ~VS_POL;
      HCount     <= '0;
      VCount     <= '0;
      FrameStart <= 1'b0;
    end else begin
      VideoDout  <= PixelReq ? pixelNext : 24'h000000;
      VideoDE    <= PixelReq;
      VideoHSync <= hsActive ? HS_POL : ~HS_POL;
      VideoVSync <= vsActive ? VS_POL : ~VS_POL;
      HCount     <= hcnt;
      VCount     <= vcnt;
      FrameStart <= PixelReq && (hcnt == 12'd0) && (vcnt == 12'd0);
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - self-checking bench for video_timing_gen on a 14x7 raster.
module tb_video_timing_gen;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        PixelClk = 1'b0;
  logic        RstB = 1'b0;
  logic        Enable = 1'b0;
  logic [23:0] PixelIn = 24'h0;
  logic        PixelReq, VideoDE, VideoHSync, VideoVSync, FrameStart, Busy;
  logic [23:0] VideoDout;
  logic [11:0] HCount, VCount;

  int checks = 0;
  int failures = 0;
  bit mRun = 1'b0;
  int mPos = 0;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .PixelClk(PixelClk), .RstB(RstB), .Enable(Enable), .PixelIn(PixelIn),
    .PixelReq(PixelReq), .VideoDout(VideoDout), .VideoDE(VideoDE),
    .VideoHSync(VideoHSync), .VideoVSync(VideoVSync), .HCount(HCount),
    .VCount(VCount), .FrameStart(FrameStart), .Busy(Busy)
  );

  always #5 PixelClk = ~PixelClk;

  function automatic logic [23:0] barColour(input int x);
    logic [23:0] bars [8];
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    return bars[x / (HA / 8)];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_req"}, 32'(PixelReq), 0);
    check({tag, "_dout"}, 32'(VideoDout), 0);
    check({tag, "_de"}, 32'(VideoDE), 0);
    check({tag, "_hs"}, 32'(VideoHSync), 0);
    check({tag, "_vs"}, 32'(VideoVSync), 0);
    check({tag, "_hc"}, 32'(HCount), 0);
    check({tag, "_vc"}, 32'(VCount), 0);
    check({tag, "_fs"}, 32'(FrameStart), 0);
    check({tag, "_busy"}, 32'(Busy), 0);
  endtask

  // One clock: predict from the raster position before the edge, then advance the model.
  task automatic cycle();
    int x, y, nx, ny;
    bit req, hsOn, vsOn, nreq;
    logic [23:0] pix;
    x = mPos % HT;
    y = mPos / HT;
    req = mRun && x < HA && y < VA;
    hsOn = mRun && x >= HA + HF && x < HA + HF + HS;
    vsOn = mRun && y >= VA + VF && y < VA + VF + VS;
`ifdef VTG_PATTERN_EN
    pix = barColour(x);
`else
    pix = PixelIn;
`endif
    @(posedge PixelClk);
    #1;
    check("de", 32'(VideoDE), 32'(req));
    check("dout", 32'(VideoDout), req ? 32'(pix) : 32'h0);
    check("hsync", 32'(VideoHSync), 32'(hsOn));
    check("vsync", 32'(VideoVSync), 32'(vsOn));
    check("hcount", 32'(HCount), 32'(x));
    check("vcount", 32'(VCount), 32'(y));
    check("framestart", 32'(FrameStart), 32'(req && mPos == 0));
    if (!mRun) begin
      if (Enable) begin
        mRun = 1'b1;
        mPos = 0;
      end
    end else if (mPos == FT - 1) begin
      mPos = 0;
      if (!Enable) mRun = 1'b0;
    end else begin
      mPos++;
    end
    nx = mPos % HT;
    ny = mPos / HT;
    nreq = mRun && nx < HA && ny < VA;
    check("busy", 32'(Busy), 32'(mRun));
    check("pixelreq", 32'(PixelReq), 32'(nreq));
  endtask

  function automatic logic [23:0] ramp();
    return {8'hA0, 16'(mPos % HT)};
  endfunction

  initial begin
    int deCount, fsCount;
    #3;
    checkReset("reset");
    @(posedge PixelClk);
    #1;
    RstB = 1'b1;
    Enable = 1'b1;

    // Two full frames with a ramp from a show-ahead source.
    for (int i = 0; i < 2 * FT + 3; i++) begin
      PixelIn = ramp();
      cycle();
    end

    // Drop Enable on line 2 of a frame: the frame must still complete.
    for (int i = 0; i < 3 * FT && !(mRun && mPos == 2 * HT); i++) begin
      PixelIn = ramp();
      cycle();
    end
    check("reach_line2", 32'(mRun && mPos == 2 * HT), 1);
    Enable = 1'b0;
    for (int i = 0; i < 2 * FT && mRun; i++) begin
      PixelIn = 24'($urandom);
      cycle();
    end
    check("stopped", 32'(mRun), 0);
    for (int i = 0; i < 10; i++) begin
      PixelIn = 24'($urandom);
      cycle();
    end

    // Restart: FrameStart two edges after Enable rises, then one frame of 32 DE cycles.
    Enable = 1'b1;
    cycle();
    cycle();
    check("restart_fs", 32'(FrameStart), 1);
    deCount = 0;
    fsCount = 0;
    for (int i = 0; i < FT; i++) begin
      PixelIn = 24'($urandom);
      cycle();
      deCount += int'(VideoDE);
      fsCount += int'(FrameStart);
    end
    check("de_per_frame", 32'(deCount), HA * VA);
    check("fs_per_frame", 32'(fsCount), 1);

    // Asynchronous reset mid-line.
    for (int i = 0; i < 2 * FT && !(mRun && mPos == HT + 3); i++) begin
      PixelIn = ramp();
      cycle();
    end
    check("reach_midline", 32'(mRun && mPos == HT + 3), 1);
    #2;
    RstB = 1'b0;
    #1;
    checkReset("async_rst");
    @(posedge PixelClk);
    #1;
    checkReset("held_rst");
    RstB = 1'b1;
    mRun = 1'b0;
    mPos = 0;
    for (int i = 0; i < FT + 5; i++) begin
      PixelIn = ramp();
      cycle();
    end

    // Randomised Enable and pixel data.
    for (int i = 0; i < 2500; i++) begin
      Enable = ($urandom_range(0, 3) != 0);
      PixelIn = 24'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
